// File: rtl/zuc_sched_pkg.sv
// Shared widths and FSM encoding for the zuc keystream-core scheduler.
package zuc_sched_pkg;

  localparam int ZUC_KEY_W  = 128;
  localparam int ZUC_IV_W   = 128;
  localparam int ZUC_WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_INIT   = 2'd1,
    ST_STREAM = 2'd2
  } state_t;

endpackage

// File: rtl/zuc_rr_arb.sv
// Round-robin arbiter: the first requester at or after i_ptr (wrapping) wins.
module zuc_rr_arb #(
  parameter  int NUM_CH = 4,
  localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [IDX_W-1:0]  i_ptr,
  output logic [NUM_CH-1:0] o_gnt,
  output logic [IDX_W-1:0]  o_idx,
  output logic              o_any
);

  int               w_c;
  logic [IDX_W-1:0] w_sel;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_c   = 0;
    w_sel = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_c = int'(i_ptr) + k;
      if (w_c >= NUM_CH) w_c = w_c - NUM_CH;
      w_sel = IDX_W'(w_c);
      if (!o_any && i_req[w_sel]) begin
        o_any        = 1'b1;
        o_gnt[w_sel] = 1'b1;
        o_idx        = w_sel;
      end
    end
  end

endmodule

// File: rtl/zuc_sched.sv
// Shares one zuc keystream core between NUM_CH requesters, one job at a time,
// streaming each job's words to a single channel-tagged output.
module zuc_sched
  import zuc_sched_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int LEN_W  = 16,
  localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [NUM_CH-1:0]           i_req_valid,
  output logic [NUM_CH-1:0]           o_req_ready,
  input  logic [NUM_CH*ZUC_KEY_W-1:0] i_req_key,
  input  logic [NUM_CH*ZUC_IV_W-1:0]  i_req_iv,
  input  logic [NUM_CH*LEN_W-1:0]     i_req_len,
  output logic                        o_m_valid,
  input  logic                        i_m_ready,
  output logic [ZUC_WORD_W-1:0]       o_m_data,
  output logic [IDX_W-1:0]            o_m_chan,
  output logic                        o_m_last,
  output logic                        o_z_s_valid,
  output logic                        o_z_s_init,
  input  logic                        i_z_s_ready,
  output logic [ZUC_KEY_W-1:0]        o_z_s_key,
  output logic [ZUC_IV_W-1:0]         o_z_s_iv,
  input  logic                        i_z_m_valid,
  output logic                        o_z_m_ready,
  input  logic [ZUC_WORD_W-1:0]       i_z_m_data,
  output state_t                      o_dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // valid never depends on ready, and a raised valid holds its payload until taken.

  state_t                r_state, w_state_nxt;
  logic [IDX_W-1:0]      r_ptr;
  logic [LEN_W-1:0]      r_cnt;
  logic [ZUC_KEY_W-1:0]  r_key;
  logic [ZUC_IV_W-1:0]   r_iv;
  logic [LEN_W-1:0]      r_len;
  logic [IDX_W-1:0]      r_chan;
  logic [NUM_CH-1:0]     r_req_ready;

  logic [NUM_CH-1:0]     w_gnt;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_any;
  logic                  w_grant;
  logic                  w_beat;
  logic [LEN_W-1:0]      w_len_sel;

  zuc_rr_arb #(.NUM_CH(NUM_CH)) u_arb (
    .i_req (i_req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  // A grant is suppressed while the previous req_ready pulse is still out, so a
  // requester that has not yet seen its accept cannot be granted twice.
  assign w_grant   = (r_state == ST_IDLE) && w_any && (r_req_ready == '0);
  assign w_len_sel = i_req_len[int'(w_idx)*LEN_W +: LEN_W];
  assign w_beat    = (r_state == ST_STREAM) && i_z_m_valid && i_m_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    o_z_s_valid = 1'b0;
    o_z_s_init  = 1'b0;
    o_m_valid   = 1'b0;
    o_z_m_ready = 1'b0;
    o_m_data    = '0;
    o_m_last    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_grant && (w_len_sel != '0)) w_state_nxt = ST_INIT;
      end
      ST_INIT: begin
        o_z_s_valid = 1'b1;
        o_z_s_init  = 1'b1;
        if (i_z_s_ready) w_state_nxt = ST_STREAM;
      end
      ST_STREAM: begin
        o_z_s_valid = 1'b1;
        o_m_valid   = i_z_m_valid;
        o_m_data    = i_z_m_data;
        o_z_m_ready = i_m_ready;
        o_m_last    = (r_cnt == r_len - LEN_W'(1));
        if (w_beat && o_m_last) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr       <= '0;
      r_cnt       <= '0;
      r_key       <= '0;
      r_iv        <= '0;
      r_len       <= '0;
      r_chan      <= '0;
      r_req_ready <= '0;
    end else begin
      r_req_ready <= w_grant ? w_gnt : '0;
      if (w_grant) begin
        r_key  <= i_req_key[int'(w_idx)*ZUC_KEY_W +: ZUC_KEY_W];
        r_iv   <= i_req_iv[int'(w_idx)*ZUC_IV_W +: ZUC_IV_W];
        r_len  <= w_len_sel;
        r_chan <= w_idx;
        r_ptr  <= (int'(w_idx) == NUM_CH - 1) ? '0 : w_idx + IDX_W'(1);
      end
      if ((r_state == ST_INIT) && i_z_s_ready) r_cnt <= '0;
      else if (w_beat)                         r_cnt <= r_cnt + LEN_W'(1);
    end
  end

  assign o_req_ready = r_req_ready;
  assign o_m_chan    = r_chan;
  assign o_z_s_key   = r_key;
  assign o_z_s_iv    = r_iv;
  assign o_dbg_state = r_state;

endmodule

// File: doc/zuc_sched.md
# zuc_sched

Round-robin scheduler that shares one `zuc` keystream core between `NUM_CH` requesters. Each requester submits a job: key, IV and a keystream length in 32-bit words. The scheduler grants one job at a time, issues the core's init beat with that job's key/IV, and streams exactly the requested number of words to a single tagged output. It sits between the per-channel cipher front ends (EEA3/EIA3 wrappers) and the `zuc` instance.

## Interface
Parameters:
- `NUM_CH`, 4, number of requesters (2..16)
- `LEN_W`, 16, width of job length field (words)

Ports:
- `clk`  in  1  clock, all logic on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `req_valid`  in  NUM_CH  per-channel job request
- `req_ready`  out  NUM_CH  per-channel job accept (one-hot or zero)
- `req_key`  in  NUM_CH*128  channel c key at `[128*c+:128]`
- `req_iv`  in  NUM_CH*128  channel c IV at `[128*c+:128]`
- `req_len`  in  NUM_CH*LEN_W  channel c length in words
- `m_valid`  out  1  keystream word valid
- `m_ready`  in  1  keystream word accept
- `m_data`  out  32  keystream word
- `m_chan`  out  $clog2(NUM_CH)  owning channel of current word
- `m_last`  out  1  final word of job
- `z_s_valid`, `z_s_init`  out  1 each  to core `s_valid`, `s_init`
- `z_s_ready`  in  1  from core `s_ready`
- `z_s_key`, `z_s_iv`  out  128 each  to core `s_key`, `s_iv`
- `z_m_valid`  in  1  from core `m_valid`
- `z_m_ready`  out  1  to core `m_ready`
- `z_m_data`  in  32  from core `m_data`

## Operation
- Core contract: an accepted beat with `s_init=1` loads key/IV, runs initialisation and discards any pending keystream; subsequent beats with `s_init=0` keep generation enabled.
- States: IDLE, INIT, STREAM.
- IDLE: if any `req_valid`, select channel by round-robin starting at `rr_ptr`; assert that channel's `req_ready` for one cycle; latch key, IV, len, chan into job registers; `rr_ptr <= chan+1` (mod NUM_CH). len≠0 → INIT; len=0 → stay IDLE, no core activity, no output.
- INIT: `z_s_valid=1`, `z_s_init=1`, key/IV from job registers; on `z_s_ready` → STREAM, `cnt <= 0`.
- STREAM: `z_s_valid=1`, `z_s_init=0`; `m_valid=z_m_valid`, `m_data=z_m_data`, `z_m_ready=m_ready`, `m_chan=job chan`, `m_last=(cnt==len-1)`. Each `m_valid&&m_ready` increments `cnt`; handshake with `m_last` → IDLE.
- Outside STREAM: `m_valid=0`, `z_m_ready=0`; core words wait and are discarded by the next init.
- `req_valid` dropped before grant: no effect; grant only to channels valid in that cycle.
- Job length is words, not bits; partial-word masking belongs to the front end.

## Timing
- Reset (async assert, sync deassert externally): state IDLE, `rr_ptr=0`, `cnt=0`, job registers 0; all outputs 0 (`req_ready`, `m_valid`, `m_last`, `z_s_valid`, `z_s_init`, `z_m_ready`, `m_data`, `m_chan`, `z_s_key`, `z_s_iv`).
- Grant: `req_ready` registered, asserted the cycle after IDLE sees `req_valid`; INIT follows next cycle.
- Keystream path: combinational `z_m_*` → `m_*`, zero added latency; `m_valid` never depends on `m_ready`.
- Back-to-back jobs: one IDLE cycle between last word and next grant.
- Reset mid-job: job lost, no `m_last` issued; next job's init reloads the core (core has no reset).
- `len` max `2^LEN_W-1`; `cnt` is LEN_W bits, no wrap.

## Structure
- Package `zuc_sched_pkg`: state encoding, `ZUC_KEY_W=128`, `ZUC_IV_W=128`, `ZUC_WORD_W=32`.
- Sub-module `zuc_rr_arb`: NUM_CH round-robin arbiter (request vector, pointer → one-hot grant + index).

## Test plan
- ch0 key=0, iv=0, len=2, `m_ready=1` → words 27bede74, 018082da, `m_chan=0`, `m_last` on second.
- ch2 key=iv=all ones, len=2, random `m_ready` → 0657cfa0, 7096398b, `m_chan=2`, data stable while stalled.
- ch0 and ch1 both valid, ch0 job1 = key 0/len 2, ch1 job = all-ones/len 2 → ch0 then ch1; second init yields 0657cfa0 with no stale words.
- All 4 channels continuously valid, len=1 → grants 0,1,2,3,0,... exactly.
- ch1 len=0 → one `req_ready` pulse, no `z_s_valid`, no `m_valid`; pointer advances to 2.
- Assert `rst_n=0` mid-STREAM → all outputs 0 immediately; following key 0/iv 0 job → 27bede74 first.
